// File: rtl/vga_move_scheduler_if.sv
// Handshake bundle between the button pins, the move scheduler and the sprite renderer.
interface vga_move_scheduler_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           frame_start;
  logic [3:0]     btn;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic [3:0]     grant;
  logic           update_pulse;
  logic           moving;

  modport master (
    output frame_start, btn,
    input  pos_x, pos_y, grant, update_pulse, moving
  );

  modport slave (
    input  frame_start, btn,
    output pos_x, pos_y, grant, update_pulse, moving
  );
endinterface

// File: rtl/vga_move_scheduler.sv
// Frame-rate sprite mover: per-frame button debounce, round-robin direction
// arbitration and clamped one-step position update.
module vga_move_scheduler #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_move_scheduler_if.slave  bus
);
  localparam int                CNT_W  = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0]  HOLD_C = CNT_W'(HOLD_FRAMES);
  localparam logic signed [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic signed [Y_W:0] STEP_Y = (Y_W+1)'(STEP);
  localparam logic signed [X_W:0] X_MAX  = (X_W+1)'(H_ACTIVE - SPRITE_W);
  localparam logic signed [Y_W:0] Y_MAX  = (Y_W+1)'(V_ACTIVE - SPRITE_H);
  localparam logic [X_W-1:0]    X_RST  = X_W'((H_ACTIVE - SPRITE_W) / 2);
  localparam logic [Y_W-1:0]    Y_RST  = Y_W'((V_ACTIVE - SPRITE_H) / 2);

  typedef enum logic [1:0] {IDLE, ARB, MOVE} state_t;

  function automatic logic [X_W-1:0] sat_x(input logic signed [X_W:0] v);
    if (v[X_W])          sat_x = '0;
    else if (v > X_MAX)  sat_x = X_MAX[X_W-1:0];
    else                 sat_x = v[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] sat_y(input logic signed [Y_W:0] v);
    if (v[Y_W])          sat_y = '0;
    else if (v > Y_MAX)  sat_y = Y_MAX[Y_W-1:0];
    else                 sat_y = v[Y_W-1:0];
  endfunction

  logic [3:0]            btn_sync_p0, btn_sync_p1;
  state_t                state_q, state_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            qual_q, qual_d;
  logic                  moving_q, moving_d;
  logic [3:0]            grant_q, grant_d;
  logic [1:0]            rr_q, rr_d;
  logic [X_W-1:0]        pos_x_q, pos_x_d;
  logic [Y_W-1:0]        pos_y_q, pos_y_d;
  logic                  upd_q, upd_d;
  logic                  found;
  logic [1:0]            sel, idx;
  logic signed [X_W:0]   x_ext;
  logic signed [Y_W:0]   y_ext;

  // Stage p0/p1: two-flop synchronizer on the raw asynchronous buttons
  always_ff @(posedge clk) begin
    btn_sync_p0 <= bus.btn;
    btn_sync_p1 <= btn_sync_p0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qual_d   = qual_q;
    moving_d = moving_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    upd_d    = 1'b0;
    found    = 1'b0;
    sel      = rr_q;
    idx      = rr_q;
    x_ext    = $signed({1'b0, pos_x_q});
    y_ext    = $signed({1'b0, pos_y_q});
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          for (int i = 0; i < 4; i++) begin
            if (!btn_sync_p1[i])       cnt_d[i] = '0;
            else if (cnt_q[i] != HOLD_C) cnt_d[i] = cnt_q[i] + 1'b1;
            qual_d[i] = (cnt_d[i] == HOLD_C);
          end
          moving_d = |qual_d;
          state_d  = ARB;
        end
      end
      ARB: begin
        if (qual_q == 4'b0000) begin
          grant_d = 4'b0000;
          state_d = IDLE;
        end else begin
          // Search starts one past the last winner so held buttons take turns.
          for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && qual_q[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          grant_d = 4'b0001 << sel;
          rr_d    = sel;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (grant_q[0]) pos_y_d = sat_y(y_ext - STEP_Y);
        if (grant_q[1]) pos_x_d = sat_x(x_ext + STEP_X);
        if (grant_q[2]) pos_y_d = sat_y(y_ext + STEP_Y);
        if (grant_q[3]) pos_x_d = sat_x(x_ext - STEP_X);
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      qual_q   <= '0;
      moving_q <= 1'b0;
      grant_q  <= '0;
      rr_q     <= 2'd3;
      pos_x_q  <= X_RST;
      pos_y_q  <= Y_RST;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qual_q   <= qual_d;
      moving_q <= moving_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.pos_x        = pos_x_q;
  assign bus.pos_y        = pos_y_q;
  assign bus.grant        = grant_q;
  assign bus.update_pulse = upd_q;
  assign bus.moving       = moving_q;
endmodule

// File: tb/tb_vga_move_scheduler.sv
// Bench for vga_move_scheduler: directed frame table, clamp runs, random frames
// against a frame-level reference model, and reset/ARB corner sequences.
module tb_vga_move_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vga_move_scheduler_if #(.X_W(10), .Y_W(10)) bus();

  vga_move_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] btn;
    logic [3:0] grant;
    int         x;
    int         y;
    logic       upd;
    logic       mov;
  } vec_t;

  vec_t tbl[12];

  // Frame-level reference model
  int         m_x, m_y, m_rr;
  int         m_cnt[4];
  logic [3:0] e_grant;
  int         e_x, e_y;
  logic       e_upd, e_mov;

  function automatic void model_reset();
    m_x = 312; m_y = 232; m_rr = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_frame(input logic [3:0] b);
    logic [3:0] q;
    int win;
    q = '0;
    win = -1;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = b[i] ? ((m_cnt[i] + 1 > 2) ? 2 : m_cnt[i] + 1) : 0;
      q[i] = (m_cnt[i] == 2);
    end
    e_mov = |q;
    if (q == 0) begin
      e_grant = '0;
      e_upd = 1'b0;
    end else begin
      for (int k = 1; k <= 4; k++)
        if (win < 0 && q[(m_rr + k) % 4]) win = (m_rr + k) % 4;
      m_rr = win;
      e_grant = 4'(1 << win);
      e_upd = 1'b1;
      case (win)
        0: m_y = (m_y - 4 < 0) ? 0 : m_y - 4;
        1: m_x = (m_x + 4 > 624) ? 624 : m_x + 4;
        2: m_y = (m_y + 4 > 464) ? 464 : m_y + 4;
        default: m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
      endcase
    end
    e_x = m_x;
    e_y = m_y;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.btn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos_x", int'(bus.pos_x), 312);
    chk("rst_pos_y", int'(bus.pos_y), 232);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_upd", int'(bus.update_pulse), 0);
    chk("rst_moving", int'(bus.moving), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input logic [3:0] b, input logic [3:0] g, input int x,
                           input int y, input logic upd, input logic mov);
    bus.btn = b;
    repeat (3) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
    chk("grant", int'(bus.grant), int'(g));
    chk("upd_early", int'(bus.update_pulse), 0);
    chk("moving", int'(bus.moving), int'(mov));
    @(posedge clk);
    #1;
    chk("pos_x", int'(bus.pos_x), x);
    chk("pos_y", int'(bus.pos_y), y);
    chk("upd", int'(bus.update_pulse), int'(upd));
    @(posedge clk);
    #1;
    chk("upd_width", int'(bus.update_pulse), 0);
  endtask

  initial begin
    logic [3:0] rb;

    tbl[0]  = '{4'b0010, 4'b0000, 312, 232, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0010, 316, 232, 1'b1, 1'b1};
    tbl[2]  = '{4'b0011, 4'b0010, 320, 232, 1'b1, 1'b1};
    tbl[3]  = '{4'b0011, 4'b0001, 320, 228, 1'b1, 1'b1};
    tbl[4]  = '{4'b0011, 4'b0010, 324, 228, 1'b1, 1'b1};
    tbl[5]  = '{4'b0011, 4'b0001, 324, 224, 1'b1, 1'b1};
    tbl[6]  = '{4'b0011, 4'b0010, 328, 224, 1'b1, 1'b1};
    tbl[7]  = '{4'b0011, 4'b0001, 328, 220, 1'b1, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 328, 220, 1'b0, 1'b0};
    tbl[9]  = '{4'b0001, 4'b0000, 328, 220, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 328, 220, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 328, 220, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      model_frame(tbl[i].btn);
      run_frame(tbl[i].btn, tbl[i].grant, tbl[i].x, tbl[i].y, tbl[i].upd, tbl[i].mov);
    end

    repeat (90) begin
      model_frame(4'b1000);
      run_frame(4'b1000, e_grant, e_x, e_y, e_upd, e_mov);
    end
    chk("clamp_left_x", int'(bus.pos_x), 0);
    repeat (70) begin
      model_frame(4'b0100);
      run_frame(4'b0100, e_grant, e_x, e_y, e_upd, e_mov);
    end
    chk("clamp_down_y", int'(bus.pos_y), 464);
    chk("clamp_x_held", int'(bus.pos_x), 0);

    rb = 4'b0000;
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
      model_frame(rb);
      run_frame(rb, e_grant, e_x, e_y, e_upd, e_mov);
    end

    // frame_start held into ARB must not start a second arbitration
    do_reset();
    model_frame(4'b0010);
    run_frame(4'b0010, e_grant, e_x, e_y, e_upd, e_mov);
    bus.btn = 4'b0010;
    repeat (3) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    chk("arb_inj_grant", int'(bus.grant), 4'b0010);
    @(posedge clk);
    #1;
    chk("arb_inj_pos_x", int'(bus.pos_x), 316);
    chk("arb_inj_upd", int'(bus.update_pulse), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("arb_inj_no_extra_x", int'(bus.pos_x), 316);
    chk("arb_inj_no_extra_upd", int'(bus.update_pulse), 0);

    // reset landing on the MOVE cycle aborts the move
    do_reset();
    model_frame(4'b0010);
    run_frame(4'b0010, e_grant, e_x, e_y, e_upd, e_mov);
    bus.btn = 4'b0010;
    repeat (3) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_grant_before", int'(bus.grant), 4'b0010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_pos_x", int'(bus.pos_x), 312);
    chk("abort_pos_y", int'(bus.pos_y), 232);
    chk("abort_upd", int'(bus.update_pulse), 0);
    chk("abort_grant", int'(bus.grant), 0);
    chk("abort_moving", int'(bus.moving), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_upd_after", int'(bus.update_pulse), 0);
    chk("abort_pos_x_after", int'(bus.pos_x), 312);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
